// File: rtl/bit_ram_sequencer.sv
// bit_ram_sequencer: single-command read-modify-write initiator for the 3-port bit RAM.
// Reads two operand cells, applies a bit-logic op, writes the result and returns it.
module bit_ram_sequencer #(
    parameter int unsigned AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [AWIDTH-1:0] cmd_addr_a,
    input  logic [AWIDTH-1:0] cmd_addr_b,
    input  logic [AWIDTH-1:0] cmd_addr_d,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_bit,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] mem_a_addr,
    input  logic              mem_a_bit,
    output logic [AWIDTH-1:0] mem_b_addr,
    input  logic              mem_b_bit,
    output logic [AWIDTH-1:0] mem_c_addr,
    output logic              mem_c_data,
    output logic              mem_c_we
);

    localparam int unsigned OPW = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        state_q,      state_d;
    logic [OPW-1:0]    op_q,         op_d;
    logic [AWIDTH-1:0] addr_d_q,     addr_d_d;
    logic [AWIDTH-1:0] mem_a_addr_q, mem_a_addr_d;
    logic [AWIDTH-1:0] mem_b_addr_q, mem_b_addr_d;
    logic [AWIDTH-1:0] mem_c_addr_q, mem_c_addr_d;
    logic              mem_c_data_q, mem_c_data_d;
    logic              mem_c_we_q,   mem_c_we_d;
    logic              cmd_ready_q,  cmd_ready_d;
    logic              rsp_valid_q,  rsp_valid_d;
    logic              rsp_bit_q,    rsp_bit_d;
    logic              rsp_err_q,    rsp_err_d;

    logic res_c;
    logic legal_c;
    logic writes_c;

    // Decode the latched opcode against the live RAM read data
    always_comb begin
        res_c    = 1'b0;
        legal_c  = 1'b1;
        writes_c = 1'b1;
        case (op_q)
            4'd0:    begin res_c = mem_a_bit; writes_c = 1'b0; end
            4'd1:    res_c = mem_a_bit;
            4'd2:    res_c = ~mem_a_bit;
            4'd3:    res_c = mem_a_bit & mem_b_bit;
            4'd4:    res_c = mem_a_bit | mem_b_bit;
            4'd5:    res_c = mem_a_bit ^ mem_b_bit;
            4'd6:    res_c = ~(mem_a_bit & mem_b_bit);
            4'd7:    res_c = ~(mem_a_bit | mem_b_bit);
            4'd8:    res_c = ~(mem_a_bit ^ mem_b_bit);
            4'd9:    res_c = 1'b1;
            4'd10:   res_c = 1'b0;
            default: begin legal_c = 1'b0; writes_c = 1'b0; end
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d_d     = addr_d_q;
        mem_a_addr_d = mem_a_addr_q;
        mem_b_addr_d = mem_b_addr_q;
        mem_c_addr_d = mem_c_addr_q;
        mem_c_data_d = mem_c_data_q;
        mem_c_we_d   = 1'b0;
        cmd_ready_d  = cmd_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_bit_d    = rsp_bit_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d         = cmd_op;
                    addr_d_d     = cmd_addr_d;
                    mem_a_addr_d = cmd_addr_a;
                    mem_b_addr_d = cmd_addr_b;
                    rsp_bit_d    = 1'b0;
                    rsp_err_d    = 1'b0;
                    cmd_ready_d  = 1'b0;
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                rsp_bit_d = res_c;
                rsp_err_d = ~legal_c;
                if (writes_c) begin
                    mem_c_addr_d = addr_d_q;
                    mem_c_data_d = res_c;
                    mem_c_we_d   = 1'b1;
                    state_d      = S_WRITE;
                end else begin
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_WRITE: begin
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset returns to IDLE with cmd_ready high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            addr_d_q     <= '0;
            mem_a_addr_q <= '0;
            mem_b_addr_q <= '0;
            mem_c_addr_q <= '0;
            mem_c_data_q <= 1'b0;
            mem_c_we_q   <= 1'b0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_bit_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_d_q     <= addr_d_d;
            mem_a_addr_q <= mem_a_addr_d;
            mem_b_addr_q <= mem_b_addr_d;
            mem_c_addr_q <= mem_c_addr_d;
            mem_c_data_q <= mem_c_data_d;
            mem_c_we_q   <= mem_c_we_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_bit_q    <= rsp_bit_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_bit    = rsp_bit_q;
    assign rsp_err    = rsp_err_q;
    assign mem_a_addr = mem_a_addr_q;
    assign mem_b_addr = mem_b_addr_q;
    assign mem_c_addr = mem_c_addr_q;
    assign mem_c_data = mem_c_data_q;
    assign mem_c_we   = mem_c_we_q;

endmodule
